// File: rtl/dmem_responder.sv
// Single-port data memory responder: one load/store in flight, fixed response latency,
// byte-enabled stores, misalignment/range checking and a held response until accepted.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;

  logic          accept;
  logic          use_req;
  logic          commit;
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;
  logic          op_err;
  logic [AW-1:0] op_idx;
  logic [31:0]   rd_word;

  // With LATENCY==1 the commit edge is the accept edge, so the live request is used.
  always_comb begin
    use_req  = (state_reg == IDLE);
    accept   = req_valid & req_ready;
    op_we    = use_req ? req_we    : we_reg;
    op_addr  = use_req ? req_addr  : addr_reg;
    op_wdata = use_req ? req_wdata : wdata_reg;
    op_be    = use_req ? req_be    : be_reg;
    op_err   = (op_addr[1:0] != 2'b00) || (op_addr[31:AW+2] != '0);
    op_idx   = op_addr[AW+1:2];
    commit   = use_req ? (accept && (LATENCY == 1))
                       : ((state_reg == WAIT) && (cnt_reg == 3'd1));
  end

  assign req_ready = (state_reg == IDLE) & ~reset;

  // One byte-wide storage lane per enable bit; contents are never reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (commit && op_we && !op_err && op_be[gi])
          mem_lane[op_idx] <= op_wdata[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = mem_lane[op_idx];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            cnt_reg   <= 3'(LATENCY - 1);
            state_reg <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Response registers load on the edge that enters RESP and clear on handshake.
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? 32'd0 : rd_word;
      end else if ((state_reg == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

endmodule
